id_ex_hazard_ctrl: RTL

//  Control side of the ID/EX pipeline register. It drives the write-enables and bubble/flush

---
 rtl/id_ex_hazard_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard control: tracks in-flight writes in EX/MEM/WB slots, stalls the front end on
// load-use hazards, flushes it on a taken branch/jump and selects EX operand forwarding.
module id_ex_hazard_ctrl #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned REG_AW         = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_RegWrite_i,
  input  logic              id_MemToReg_i,
  input  logic              ex_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [1:0]        stall_cnt_o
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [1:0] StallInit = 2'(LOAD_USE_STALL - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              ex_v_q, ex_v_d;
  logic              ex_mtr_q, ex_mtr_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              mem_v_q, mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              wb_v_q, wb_v_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

  logic              ex_hit, mem_hit, wb_hit;
  logic              hz;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]        fwd_a, fwd_b;

  // A slot writing r0 never produces a usable value, so it never matches.
  assign ex_hit  = ex_v_q  & (ex_rd_q  != '0);
  assign mem_hit = mem_v_q & (mem_rd_q != '0);
  assign wb_hit  = wb_v_q  & (wb_rd_q  != '0);

  assign hz = ex_hit & ex_mtr_q &
              ((id_use_rs_i & (id_rs_i == ex_rd_q)) | (id_use_rt_i & (id_rt_i == ex_rd_q)));

  // Stall/flush FSM; flush wins over any stall and aborts a pending one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (ex_taken_i) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StRun;
      cnt_d       = 2'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = StStall;
            cnt_d       = StallInit;
          end
        end
        StStall: begin
          if (cnt_q != 2'd0) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - 2'd1;
          end else begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Register fields always follow ID; a bubble only kills the write and load flags.
  always_comb begin
    ex_v_d   = idex_bubble ? 1'b0 : id_RegWrite_i;
    ex_mtr_d = idex_bubble ? 1'b0 : id_MemToReg_i;
    ex_rs_d  = id_rs_i;
    ex_rt_d  = id_rt_i;
    ex_rd_d  = id_rd_i;
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    wb_v_d   = mem_v_q;
    wb_rd_d  = mem_rd_q;
  end

  always_comb begin
    fwd_a = 2'b00;
    if (mem_hit && (mem_rd_q == ex_rs_q)) begin
      fwd_a = 2'b10;
    end else if (wb_hit && (wb_rd_q == ex_rs_q)) begin
      fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_hit && (mem_rd_q == ex_rt_q)) begin
      fwd_b = 2'b10;
    end else if (wb_hit && (wb_rd_q == ex_rt_q)) begin
      fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StRun;
      cnt_q    <= 2'd0;
      ex_v_q   <= 1'b0;
      ex_mtr_q <= 1'b0;
      ex_rs_q  <= '0;
      ex_rt_q  <= '0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      wb_v_q   <= 1'b0;
      wb_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_v_q   <= ex_v_d;
      ex_mtr_q <= ex_mtr_d;
      ex_rs_q  <= ex_rs_d;
      ex_rt_q  <= ex_rt_d;
      ex_rd_q  <= ex_rd_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      wb_v_q   <= wb_v_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // While reset is held, a live ex_taken_i must not leak out as a flush/bubble.
  assign pc_write_o    = pc_write   | ~rst_n_i;
  assign ifid_write_o  = ifid_write | ~rst_n_i;
  assign ifid_flush_o  = ifid_flush  & rst_n_i;
  assign idex_bubble_o = idex_bubble & rst_n_i;
  assign fwd_a_o       = fwd_a;
  assign fwd_b_o       = fwd_b;
  assign stall_cnt_o   = (state_q == StStall) ? cnt_q : 2'd0;

endmodule
